// File: rtl/glb_weight_fetch_pkg.sv
// Shared types for the weight-GLB fetch sequencer: FSM encoding and the
// sideband tag carried alongside each weight through the output FIFO.
package glb_weight_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } fetch_state_t;

    // Tag layout is {row, col, last}; widths follow the top-level parameters.
    function automatic int tag_width(input int row_bits, input int col_bits);
        return row_bits + col_bits + 1;
    endfunction

    localparam int DEFAULT_TAG_BITS = 4 + 4 + 1;

endpackage

// File: rtl/glb_weight_fetch_fifo.sv
// Small synchronous FIFO holding captured weights plus tags until the PE side
// accepts them; supports push and pop in the same cycle.
module weight_out_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 head_data,
    output logic [$clog2(DEPTH + 1)-1:0]     count
);
    localparam int PTR_BITS   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_BITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_reg;
    logic [PTR_BITS-1:0]   rd_ptr_reg;
    logic [COUNT_BITS-1:0] count_reg;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != COUNT_BITS'(DEPTH)) || do_pop);

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_BITS'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_BITS'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/glb_weight_fetch.sv
// Walks a rectangular filter region in the weight GLB and streams each weight,
// tagged with its row/col, to the PE filter scratchpads.
module glb_weight_fetch
    import glb_weight_fetch_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int ROW_BITWIDTH  = 4,
    parameter int COL_BITWIDTH  = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BITWIDTH-1:0] cfg_base_addr,
    input  logic [ROW_BITWIDTH-1:0]  cfg_rows,
    input  logic [COL_BITWIDTH-1:0]  cfg_row_len,
    input  logic [ADDR_BITWIDTH-1:0] cfg_row_stride,
    output logic                     busy,
    output logic                     done,
    output logic                     read_req,
    output logic [ADDR_BITWIDTH-1:0] r_addr,
    input  logic [DATA_BITWIDTH-1:0] r_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic [ROW_BITWIDTH-1:0]  out_row,
    output logic [COL_BITWIDTH-1:0]  out_col,
    output logic                     out_last
);
    localparam int TAG_BITS   = tag_width(ROW_BITWIDTH, COL_BITWIDTH);
    localparam int ENTRY_BITS = DATA_BITWIDTH + TAG_BITS;
    localparam int COUNT_BITS = $clog2(FIFO_DEPTH + 1);

    fetch_state_t              state_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic [ADDR_BITWIDTH-1:0]  row_base_reg;
    logic [ROW_BITWIDTH-1:0]   row_reg;
    logic [COL_BITWIDTH-1:0]   col_reg;
    logic [ROW_BITWIDTH-1:0]   rows_cfg_reg;
    logic [COL_BITWIDTH-1:0]   len_cfg_reg;
    logic [ADDR_BITWIDTH-1:0]  stride_cfg_reg;
    logic                      inflight_reg;
    logic [TAG_BITS-1:0]       tag_reg;

    logic                      row_end;
    logic                      issue_last;
    logic                      credit_ok;
    logic                      pop;
    logic [COUNT_BITS-1:0]     fifo_count;
    logic [ENTRY_BITS-1:0]     head_entry;
    logic                      head_last;

    assign row_end    = (col_reg == len_cfg_reg - 1'b1);
    assign issue_last = row_end && (row_reg == rows_cfg_reg - 1'b1);

    // Reads already in flight will land in the FIFO; a same-cycle pop frees a slot.
    assign credit_ok = ({1'b0, fifo_count} + {{COUNT_BITS{1'b0}}, inflight_reg})
                       < ((COUNT_BITS + 1)'(FIFO_DEPTH) + {{COUNT_BITS{1'b0}}, pop});

    assign read_req = (state_reg == ST_FETCH) && credit_ok;
    assign r_addr   = row_base_reg + ADDR_BITWIDTH'(col_reg);

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign head_last = head_entry[0];
    assign out_last  = out_valid && head_last;
    assign out_col   = out_valid ? head_entry[COL_BITWIDTH:1] : '0;
    assign out_row   = out_valid ? head_entry[COL_BITWIDTH+ROW_BITWIDTH:COL_BITWIDTH+1] : '0;
    assign out_data  = out_valid ? head_entry[ENTRY_BITS-1:TAG_BITS] : '0;

    assign busy = busy_reg;
    assign done = done_reg;

    weight_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_reg),
        .push_data ({r_data, tag_reg}),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            row_base_reg   <= '0;
            row_reg        <= '0;
            col_reg        <= '0;
            rows_cfg_reg   <= '0;
            len_cfg_reg    <= '0;
            stride_cfg_reg <= '0;
            inflight_reg   <= 1'b0;
            tag_reg        <= '0;
        end else begin
            done_reg     <= 1'b0;
            inflight_reg <= read_req;
            if (read_req) begin
                tag_reg <= {row_reg, col_reg, issue_last};
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        row_base_reg   <= cfg_base_addr;
                        rows_cfg_reg   <= cfg_rows;
                        len_cfg_reg    <= cfg_row_len;
                        stride_cfg_reg <= cfg_row_stride;
                        row_reg        <= '0;
                        col_reg        <= '0;
                        if ((cfg_rows == '0) || (cfg_row_len == '0)) begin
                            state_reg <= ST_FINISH;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_FETCH;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (read_req) begin
                        if (row_end) begin
                            col_reg      <= '0;
                            row_reg      <= row_reg + 1'b1;
                            row_base_reg <= row_base_reg + stride_cfg_reg;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                        if (issue_last) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Final entry alone at the head with nothing landing behind it.
                    if (!inflight_reg && (fifo_count == COUNT_BITS'(1)) && pop && head_last) begin
                        state_reg <= ST_FINISH;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glb_weight_fetch.sv
// Self-checking bench for glb_weight_fetch: directed vector table, randomized
// regions against a nested-loop reference model, and a mid-run reset sequence.
module tb_glb_weight_fetch;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int RW = 4;
    localparam int CW = 4;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] cfg_base_addr;
    logic [RW-1:0] cfg_rows;
    logic [CW-1:0] cfg_row_len;
    logic [AW-1:0] cfg_row_stride;
    logic          busy;
    logic          done;
    logic          read_req;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int data;
        int row;
        int col;
        bit last;
    } item_t;

    typedef struct {
        int base;
        int rows;
        int len;
        int stride;
        int ready_mode;
        bit restart;
        int exp_count;
        int exp_first;
        int exp_final;
    } vec_t;

    item_t exp_q[$];
    vec_t  vecs[6];

    always #5 clk = ~clk;

    // GLB: data for mem[a] = a + 100 appears one cycle after the request, filler otherwise.
    always @(posedge clk) begin
        if (read_req) r_data <= DW'(r_addr) + 16'd100;
        else          r_data <= DW'($urandom);
    end

    glb_weight_fetch #(
        .DATA_BITWIDTH (DW),
        .ADDR_BITWIDTH (AW),
        .ROW_BITWIDTH  (RW),
        .COL_BITWIDTH  (CW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_rows       (cfg_rows),
        .cfg_row_len    (cfg_row_len),
        .cfg_row_stride (cfg_row_stride),
        .busy           (busy),
        .done           (done),
        .read_req       (read_req),
        .r_addr         (r_addr),
        .r_data         (r_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_row        (out_row),
        .out_col        (out_col),
        .out_last       (out_last)
    );

    task automatic check(input string name, input longint actual, input longint required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic run_job(input vec_t v, input string name);
        item_t it;
        int    accepts = 0;
        int    reads = 0;
        int    done_cnt = 0;
        int    done_i = -1;
        int    last_acc = -10;
        int    first_valid = -1;
        int    first_data = -1;
        int    final_data = -1;
        bit    zero;
        bit    stalled = 1'b0;
        bit    pop_now;
        bit    exp_busy;
        longint held = 0;
        longint cur;

        zero = (v.rows == 0) || (v.len == 0);
        exp_q.delete();
        for (int r = 0; r < v.rows; r++) begin
            for (int c = 0; c < v.len; c++) begin
                it.data = ((v.base + r * v.stride + c) % 1024) + 100;
                it.row  = r;
                it.col  = c;
                it.last = (r == v.rows - 1) && (c == v.len - 1);
                exp_q.push_back(it);
            end
        end

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = (i == 0) || (v.restart && i == 4);
            if (i == 0) begin
                cfg_base_addr  = AW'(v.base);
                cfg_rows       = RW'(v.rows);
                cfg_row_len    = CW'(v.len);
                cfg_row_stride = AW'(v.stride);
            end else begin
                cfg_base_addr  = AW'($urandom);
                cfg_rows       = RW'($urandom_range(1, 15));
                cfg_row_len    = CW'($urandom_range(1, 15));
                cfg_row_stride = AW'($urandom);
            end
            case (v.ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (i % 4 == 0) || (i % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            cur = {out_valid, out_data, out_row, out_col, out_last};
            pop_now = out_valid && out_ready;
            if (stalled) check({name, "_stall_hold"}, cur, held);
            if (out_valid && first_valid < 0) first_valid = i;
            if (read_req) begin
                check({name, "_credit"}, ((reads - accepts) + 1 - int'(pop_now)) <= DEPTH, 1);
                reads++;
            end
            exp_busy = !zero && (i >= 1) && (done_i < 0) && !done;
            check({name, "_busy"}, busy, exp_busy);
            if (done) begin
                done_cnt++;
                if (done_i < 0) begin
                    done_i = i;
                    check({name, "_done_time"}, i, zero ? 1 : last_acc + 1);
                end
            end
            if (pop_now) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra_output"}, out_data, -1);
                end else begin
                    it = exp_q.pop_front();
                    check({name, "_data"}, out_data, it.data);
                    check({name, "_rowcol"}, {out_row, out_col}, {RW'(it.row), CW'(it.col)});
                    check({name, "_last"}, out_last, it.last);
                end
                if (accepts == 0) first_data = out_data;
                final_data = out_data;
                accepts++;
                last_acc = i;
            end
            stalled = out_valid && !out_ready;
            held = cur;
            if (done_i >= 0 && i >= done_i + 3) break;
        end
        start = 1'b0;

        check({name, "_done_seen"}, done_i >= 0, 1);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_count"}, accepts, v.exp_count);
        check({name, "_first"}, first_data, v.exp_first);
        check({name, "_final"}, final_data, v.exp_final);
        check({name, "_reads"}, reads, v.rows * v.len);
        check({name, "_latency"}, first_valid, zero ? -1 : 3);
        $display("job %s base=%0d rows=%0d len=%0d stride=%0d outputs=%0d", name,
                 v.base, v.rows, v.len, v.stride, accepts);
    endtask

    initial begin
        vec_t rv;
        int   acc;
        bit   hit;

        // base rows len stride ready restart count first final
        vecs[0] = '{0,    3, 3, 3, 0, 1'b0, 9, 100,  108};
        vecs[1] = '{1020, 2, 3, 4, 0, 1'b0, 6, 1120, 102};
        vecs[2] = '{0,    3, 3, 3, 1, 1'b0, 9, 100,  108};
        vecs[3] = '{0,    0, 3, 3, 0, 1'b0, 0, -1,   -1};
        vecs[4] = '{5,    2, 0, 3, 0, 1'b0, 0, -1,   -1};
        vecs[5] = '{0,    3, 3, 3, 0, 1'b1, 9, 100,  108};

        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        cfg_base_addr = '0;
        cfg_rows = '0;
        cfg_row_len = '0;
        cfg_row_stride = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {busy, done, read_req, r_addr, out_valid, out_data, out_row, out_col, out_last}, 0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_job(vecs[k], $sformatf("vec%0d", k));
        end

        for (int k = 0; k < 8; k++) begin
            rv.base       = $urandom_range(0, 1023);
            rv.rows       = $urandom_range(1, 4);
            rv.len        = $urandom_range(1, 5);
            rv.stride     = $urandom_range(0, 1023);
            rv.ready_mode = 2;
            rv.restart    = ($urandom_range(0, 1) == 1);
            rv.exp_count  = rv.rows * rv.len;
            rv.exp_first  = rv.base + 100;
            rv.exp_final  = ((rv.base + (rv.rows - 1) * rv.stride + rv.len - 1) % 1024) + 100;
            run_job(rv, $sformatf("rand%0d", k));
        end

        // Reset while the fifth weight is presented.
        acc = 0;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            start = (i == 0);
            cfg_base_addr = '0;
            cfg_rows = RW'(3);
            cfg_row_len = CW'(3);
            cfg_row_stride = AW'(3);
            out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) begin
                if (acc == 4) begin
                    check("rst_5th_data", out_data, 104);
                    reset = 1'b1;
                    hit = 1'b1;
                end
                acc++;
            end
        end
        start = 1'b0;
        check("rst_hit", hit, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_outputs", {busy, done, read_req, r_addr, out_valid, out_data, out_row, out_col, out_last}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("rst_quiet", {done, busy, out_valid, read_req}, 0);
        end
        $display("job reset_abort outputs_before_reset=%0d", acc - 1);
        run_job(vecs[0], "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glb_weight_fetch.md
Name: glb_weight_fetch

Overview:
- Sequencer between the weight global buffer and the PE-array filter scratchpads.
- On `start`, walks a rectangular filter region (`cfg_rows` rows × `cfg_row_len` weights, row stride `cfg_row_stride`) starting at `cfg_base_addr`.
- Issues `read_req`/`r_addr` to the weight GLB and captures `r_data` exactly one cycle later.
- Forwards each weight on a valid/ready stream tagged with PE row and column index; a small output FIFO absorbs PE-side backpressure.

Parameters:
- DATA_BITWIDTH, 16, weight width; matches the GLB data port.
- ADDR_BITWIDTH, 10, GLB address width.
- ROW_BITWIDTH, 4, width of `cfg_rows` and `out_row`.
- COL_BITWIDTH, 4, width of `cfg_row_len` and `out_col`.
- FIFO_DEPTH, 2, output buffer entries; must be ≥ 2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; latches cfg_* when idle
- cfg_base_addr  in  ADDR_BITWIDTH  first GLB address
- cfg_rows  in  ROW_BITWIDTH  number of filter rows
- cfg_row_len  in  COL_BITWIDTH  weights per row
- cfg_row_stride  in  ADDR_BITWIDTH  address delta between row starts
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last weight accepted
- read_req  out  1  GLB read strobe
- r_addr  out  ADDR_BITWIDTH  GLB read address
- r_data  in  DATA_BITWIDTH  GLB read data, valid one cycle after read_req
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from PE spad loader
- out_data  out  DATA_BITWIDTH  weight
- out_row  out  ROW_BITWIDTH  PE/filter row index
- out_col  out  COL_BITWIDTH  index within row
- out_last  out  1  marks final weight of the region

Behaviour:
- Reset (synchronous, active-high, clk): state IDLE; all outputs 0; FIFO emptied; in-flight read discarded.
- Reset mid-operation aborts with no done pulse.
- FSM states:
  - IDLE: `start` latches cfg_* and clears row/col counters.
    - `cfg_rows==0` or `cfg_row_len==0`: go to FINISH; no reads issued.
    - Otherwise: go to FETCH; busy=1 from the next cycle.
  - FETCH: issue one read per cycle while credit is available.
    - Address = `row_base + col`, mod 2^ADDR_BITWIDTH (wrap allowed).
    - `row_base` starts at `cfg_base_addr` and increments by `cfg_row_stride` at each row end.
    - `col` wraps at `cfg_row_len`; `row` increments at the same time.
    - When the last element is issued, go to DRAIN.
  - DRAIN: wait until the in-flight read has landed, the FIFO is empty, and the last entry has been accepted; then go to FINISH.
  - FINISH: done=1 for exactly one cycle, busy=0, go to IDLE.
- `start` while not IDLE is ignored; cfg_* are sampled only on an accepted start.
- Read-data capture:
  - Registered `inflight` bit plus tag (row, col, last) is set on the cycle read_req=1.
  - On the next cycle, `r_data` plus the tag is pushed into the FIFO.
  - `r_data` is never sampled in any other cycle; the GLB drives filler when not reading.
- Credit rule: read_req=1 only if `fifo_count + inflight − (out_valid & out_ready) < FIFO_DEPTH`.
  - This gives full throughput (one weight per cycle) with continuous `out_ready`.
  - The FIFO can never overflow.
- Stream: out_* reflect the FIFO head. An entry retires on out_valid & out_ready.
  - Simultaneous push and pop is allowed; count is unchanged.
  - out_valid, once high, stays high with stable data until accepted.
- Latency: first out_valid is 3 cycles after the start cycle (latch, read, capture).

Decomposition:
- Shared package: FSM state encoding (IDLE, FETCH, DRAIN, FINISH) and the tag struct/width constant (ROW_BITWIDTH + COL_BITWIDTH + 1).
- One sub-module: `weight_out_fifo` (synchronous FIFO, DEPTH/WIDTH parameters, push/pop/count, pop-and-push on the same cycle, reset to empty).

Test Plan:
- GLB model `mem[a]=a+100`; base=0, rows=3, len=3, stride=3; out_ready=1 → 9 outputs, data 100..108 on consecutive cycles; (row,col) (0,0)..(2,2); out_last only on 108; done one cycle after the last accept; busy low the cycle done is high.
- base=1020, rows=2, len=3, stride=4 → addresses 1020,1021,1022,1024→0,1,2; data 1120,1121,1122,100,101,102; wrap verified.
- Same as the first test, with out_ready toggled 1-0-0-1 repeatedly → no loss or duplication; out_data stable while stalled; read_req never issued when the credit rule forbids; FIFO count ≤ 2.
- rows=0 (or len=0) → no read_req ever; done pulses once; busy never rises.
- `start` pulsed again mid-FETCH with different cfg → ignored; output sequence identical to the single-start run.
- `reset` asserted during the 5th output → next cycle all outputs 0, FIFO empty; a new start then produces a full clean sequence from row 0, col 0.
